// File: rtl/sram_async_ctrl.sv
// Single-word asynchronous SRAM controller with programmable setup/strobe/hold/turnaround timing.
// Optional post-write verify read is enabled by defining SRAM_WR_READBACK_EN.
module sram_async_ctrl #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WR_CYCLES    = 3,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned RD_CYCLES    = 3,
  parameter int unsigned TURN_CYCLES  = 1
) (
  input  logic        s_clk,
  input  logic        s_rst,
  input  logic        s_req,
  input  logic        s_wr_req,
  input  logic        s_rd_req,
  input  logic [15:0] s_addr,
  input  logic [15:0] s_wdata,
  output logic [15:0] s_rdata,
  output logic        s_valid,
  output logic        s_busy,
  output logic        s_err,
  input  logic        s_err_clr,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned SumCycles =
    SETUP_CYCLES + WR_CYCLES + HOLD_CYCLES + RD_CYCLES + TURN_CYCLES;
  localparam int unsigned CntW = $clog2(SumCycles + 1);

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] WrLd    = CntW'(WR_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RdLd    = CntW'(RD_CYCLES - 1);
  localparam logic [CntW-1:0] TurnLd  = CntW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StRdStrobe,
    StTurn
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       addr_q, wdata_q, rdata_q;
  logic              valid_q, err_q;
  logic              dq_oe_q, ce_n_q, oe_n_q, we_n_q, bytes_n_q;

  logic              is_idle, any_req, accept, rd_done, err_set;
  logic              verify_rd, verify_go, verify_err;

  assign is_idle = (state_q == StIdle);
  assign any_req = s_wr_req | s_rd_req;
  assign accept  = is_idle & any_req;
  assign rd_done = (state_q == StRdStrobe) && (cnt_q == '0);

`ifdef SRAM_WR_READBACK_EN
  logic verify_pend_q, verify_rd_q;
  assign verify_go  = verify_pend_q;
  assign verify_rd  = verify_rd_q;
  assign verify_err = verify_rd_q & rd_done & (sram_dq_i != wdata_q);
`else
  assign verify_go  = 1'b0;
  assign verify_rd  = 1'b0;
  assign verify_err = 1'b0;
`endif

  // Dual request in idle, or any request while busy, is a protocol error.
  assign err_set = (is_idle & s_wr_req & s_rd_req) | (~is_idle & any_req) | verify_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
    unique case (state_q)
      StIdle: begin
        if (s_wr_req) begin
          state_d = StWrSetup;
          cnt_d   = SetupLd;
        end else if (s_rd_req) begin
          state_d = StRdStrobe;
          cnt_d   = RdLd;
        end
      end
      StWrSetup: begin
        if (cnt_q == '0) begin
          state_d = StWrPulse;
          cnt_d   = WrLd;
        end
      end
      StWrPulse: begin
        if (cnt_q == '0) begin
          state_d = StWrHold;
          cnt_d   = HoldLd;
        end
      end
      StWrHold: begin
        if (cnt_q == '0) begin
          state_d = StTurn;
          cnt_d   = TurnLd;
        end
      end
      StRdStrobe: begin
        if (cnt_q == '0) begin
          state_d = StTurn;
          cnt_d   = TurnLd;
        end
      end
      StTurn: begin
        if (cnt_q == '0) begin
          state_d = verify_go ? StRdStrobe : StIdle;
          cnt_d   = verify_go ? RdLd : '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they align with the state they belong to.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      dq_oe_q   <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      bytes_n_q <= 1'b1;
`ifdef SRAM_WR_READBACK_EN
      verify_pend_q <= 1'b0;
      verify_rd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= s_addr;
        wdata_q <= s_wdata;
      end
      valid_q <= rd_done & ~verify_rd;
      if (rd_done && !verify_rd) begin
        rdata_q <= sram_dq_i;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (s_err_clr) begin
        err_q <= 1'b0;
      end
      dq_oe_q   <= (state_d == StWrSetup) || (state_d == StWrPulse) || (state_d == StWrHold);
      ce_n_q    <= ((state_d == StIdle) || (state_d == StTurn)) ? ~s_req : 1'b0;
      oe_n_q    <= (state_d != StRdStrobe);
      we_n_q    <= (state_d != StWrPulse);
      bytes_n_q <= (state_d == StIdle) || (state_d == StTurn);
`ifdef SRAM_WR_READBACK_EN
      if (accept && s_wr_req) begin
        verify_pend_q <= 1'b1;
      end else if ((state_q == StTurn) && (cnt_q == '0) && verify_pend_q) begin
        verify_pend_q <= 1'b0;
      end
      if ((state_q == StTurn) && (cnt_q == '0) && verify_pend_q) begin
        verify_rd_q <= 1'b1;
      end else if (rd_done) begin
        verify_rd_q <= 1'b0;
      end
`endif
    end
  end

  assign s_busy     = ~is_idle | any_req;
  assign s_rdata    = rdata_q;
  assign s_valid    = valid_q;
  assign s_err      = err_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = bytes_n_q;
  assign sram_lb_n  = bytes_n_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed self-checking bench for sram_async_ctrl with a small behavioural SRAM model.
module tb_sram_async_ctrl;

`ifdef SRAM_WR_READBACK_EN
  localparam int WrLast = 10;
`else
  localparam int WrLast = 6;
`endif

  logic        s_clk = 1'b0;
  logic        s_rst, s_req, s_wr_req, s_rd_req, s_err_clr;
  logic [15:0] s_addr, s_wdata, s_rdata, sram_addr, sram_dq_o, sram_dq_i;
  logic        s_valid, s_busy, s_err, sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic        corrupt;
  logic [15:0] mem [0:255];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 s_clk = ~s_clk;

  sram_async_ctrl dut (
    .s_clk      (s_clk),
    .s_rst      (s_rst),
    .s_req      (s_req),
    .s_wr_req   (s_wr_req),
    .s_rd_req   (s_rd_req),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
    .s_valid    (s_valid),
    .s_busy     (s_busy),
    .s_err      (s_err),
    .s_err_clr  (s_err_clr),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  always @(posedge s_clk) begin
    if (!sram_we_n && !sram_ce_n) mem[sram_addr[7:0]] <= sram_dq_o;
  end
  assign sram_dq_i = sram_oe_n ? 16'h0000 : (mem[sram_addr[7:0]] ^ {15'b0, corrupt});

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    repeat (3) tick();
    s_rst = 1'b0;
    repeat (2) tick();
    n_assert++;
    if (sram_ce_n !== 1'b0) begin
      n_fail++; $display("FAIL reset_ce_n got %b want 0", sram_ce_n);
    end
    n_assert++;
    if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 5'b11110) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 11110",
               {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
    end
    n_assert++;
    if ({s_busy, s_valid, s_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {s_busy, s_valid, s_err});
    end
    n_assert++;
    if (s_rdata !== 16'h0000 || sram_addr !== 16'h0000 || sram_dq_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data got rdata=%h addr=%h dq_o=%h want 0000", s_rdata, sram_addr,
               sram_dq_o);
    end
  endtask

  // Write with optional read pulse injected at cycle rd_at (0 = none).
  task automatic test_write(input string name, input logic [15:0] a, input logic [15:0] d,
                            input int rd_at);
    logic e_oe, e_we_n, e_busy;
    s_addr = a; s_wdata = d; s_wr_req = 1'b1;
    #1;
    n_assert++;
    if (s_busy !== 1'b1) begin
      n_fail++; $display("FAIL %s_busy_T got %b want 1", name, s_busy);
    end
    for (int c = 1; c <= WrLast + 1; c++) begin
      tick();
      s_wr_req = 1'b0;
      s_rd_req = (c == rd_at);
      #1;
      e_oe   = (c <= 5);
      e_we_n = !(c >= 2 && c <= 4);
      e_busy = (c <= WrLast);
      n_assert++;
      if (sram_dq_oe !== e_oe) begin
        n_fail++; $display("FAIL %s_dq_oe c=%0d got %b want %b", name, c, sram_dq_oe, e_oe);
      end
      n_assert++;
      if (sram_we_n !== e_we_n) begin
        n_fail++; $display("FAIL %s_we_n c=%0d got %b want %b", name, c, sram_we_n, e_we_n);
      end
      n_assert++;
      if (s_busy !== e_busy) begin
        n_fail++; $display("FAIL %s_busy c=%0d got %b want %b", name, c, s_busy, e_busy);
      end
      n_assert++;
      if (s_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s_valid c=%0d got %b want 0", name, c, s_valid);
      end
      if (c <= 6) begin
        n_assert++;
        if (sram_oe_n !== 1'b1) begin
          n_fail++; $display("FAIL %s_oe_n c=%0d got %b want 1", name, c, sram_oe_n);
        end
      end
      if (!e_we_n) begin
        n_assert++;
        if (sram_addr !== a || sram_dq_o !== d || sram_ce_n !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_bus c=%0d got addr=%h dq=%h ce_n=%b want addr=%h dq=%h ce_n=0",
                   name, c, sram_addr, sram_dq_o, sram_ce_n, a, d);
        end
      end
    end
    s_rd_req = 1'b0;
  endtask

  task automatic test_read(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic e_oe_n, e_valid, e_busy;
    s_addr = a; s_rd_req = 1'b1;
    #1;
    n_assert++;
    if (s_busy !== 1'b1) begin
      n_fail++; $display("FAIL %s_busy_T got %b want 1", name, s_busy);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      s_rd_req = 1'b0;
      #1;
      e_oe_n  = !(c >= 1 && c <= 3);
      e_valid = (c == 4);
      e_busy  = (c <= 4);
      n_assert++;
      if (sram_oe_n !== e_oe_n || sram_dq_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_oe c=%0d got oe_n=%b dq_oe=%b want oe_n=%b dq_oe=0", name, c,
                 sram_oe_n, sram_dq_oe, e_oe_n);
      end
      n_assert++;
      if (s_valid !== e_valid) begin
        n_fail++; $display("FAIL %s_valid c=%0d got %b want %b", name, c, s_valid, e_valid);
      end
      n_assert++;
      if (s_busy !== e_busy) begin
        n_fail++; $display("FAIL %s_busy c=%0d got %b want %b", name, c, s_busy, e_busy);
      end
      if (c >= 4) begin
        n_assert++;
        if (s_rdata !== exp) begin
          n_fail++; $display("FAIL %s_rdata c=%0d got %h want %h", name, c, s_rdata, exp);
        end
      end
    end
  endtask

  task automatic test_err_clr(input string name);
    s_err_clr = 1'b1;
    tick();
    s_err_clr = 1'b0;
    n_assert++;
    if (s_err !== 1'b0) begin
      n_fail++; $display("FAIL %s_err_clr got %b want 0", name, s_err);
    end
  endtask

  task automatic test_busy_error();
    test_write("wr_busy", 16'h0010, 16'hC0DE, 2);
    n_assert++;
    if (s_err !== 1'b1) begin
      n_fail++; $display("FAIL busy_err got %b want 1", s_err);
    end
    n_assert++;
    if (s_rdata !== 16'h5A3C) begin
      n_fail++; $display("FAIL busy_rdata got %h want 5a3c", s_rdata);
    end
    test_err_clr("busy");
  endtask

  task automatic test_dual_req_and_reset();
    s_addr = 16'h0002; s_wdata = 16'h1111; s_wr_req = 1'b1; s_rd_req = 1'b1;
    for (int c = 1; c <= WrLast + 1; c++) begin
      tick();
      s_wr_req = 1'b0; s_rd_req = 1'b0;
      if (c == 2) begin
        n_assert++;
        if (sram_we_n !== 1'b0) begin
          n_fail++; $display("FAIL dual_we_n got %b want 0", sram_we_n);
        end
      end
      if (c <= 3) begin
        n_assert++;
        if (sram_oe_n !== 1'b1) begin
          n_fail++; $display("FAIL dual_oe_n c=%0d got %b want 1", c, sram_oe_n);
        end
      end
      n_assert++;
      if (s_valid !== 1'b0) begin
        n_fail++; $display("FAIL dual_valid c=%0d got %b want 0", c, s_valid);
      end
    end
    n_assert++;
    if (s_err !== 1'b1 || mem[8'h02] !== 16'h1111) begin
      n_fail++; $display("FAIL dual_err got err=%b mem=%h want err=1 mem=1111", s_err, mem[8'h02]);
    end
    test_err_clr("dual");
    s_addr = 16'h0003; s_wdata = 16'h2222; s_wr_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      s_wr_req = 1'b0;
      s_rst = (c == 3);
    end
    #1;
    n_assert++;
    if ({sram_we_n, sram_dq_oe, s_busy, s_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_strobes got we_n,dq_oe,busy,valid=%b want 1000",
               {sram_we_n, sram_dq_oe, s_busy, s_valid});
    end
    n_assert++;
    if (s_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL abort_rdata got %h want 0000", s_rdata);
    end
    s_rst = 1'b0;
    tick();
  endtask

`ifdef SRAM_WR_READBACK_EN
  task automatic test_readback(input string name, input logic bad, input logic exp_err);
    logic seen_valid = 1'b0;
    logic done = 1'b0;
    corrupt = bad;
    s_addr = 16'h0040; s_wdata = 16'h00FF; s_wr_req = 1'b1;
    for (int c = 1; c <= 30 && !done; c++) begin
      tick();
      s_wr_req = 1'b0;
      if (s_valid) seen_valid = 1'b1;
      if (!s_busy) done = 1'b1;
    end
    n_assert++;
    if (!done) begin
      n_fail++; $display("FAIL %s_timeout got busy=%b want 0", name, s_busy);
    end
    n_assert++;
    if (s_err !== exp_err || seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got err=%b valid_seen=%b want err=%b valid_seen=0", name, s_err,
               seen_valid, exp_err);
    end
    n_assert++;
    if (s_rdata !== 16'hA5C3) begin
      n_fail++; $display("FAIL %s_rdata got %h want a5c3", name, s_rdata);
    end
    corrupt = 1'b0;
    test_err_clr(name);
  endtask
`endif

  initial begin
    s_rst = 1'b1; s_req = 1'b1; s_wr_req = 1'b0; s_rd_req = 1'b0; s_err_clr = 1'b0;
    s_addr = 16'h0; s_wdata = 16'h0; corrupt = 1'b0;
    test_reset();
    test_write("wr1", 16'h1234, 16'hA5C3, 0);
    test_read("rd1", 16'h1234, 16'hA5C3);
    test_write("wr2", 16'h0001, 16'h5A3C, 0);
    test_read("rd2", 16'h0001, 16'h5A3C);
    test_busy_error();
    test_dual_req_and_reset();
    test_read("rd3", 16'h1234, 16'hA5C3);
`ifdef SRAM_WR_READBACK_EN
    test_readback("rb_bad", 1'b1, 1'b1);
    test_readback("rb_good", 1'b0, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_async_ctrl.md
Name: sram_async_ctrl

Overview:
- Responder end of the s_* request interface driven by the GDP/SRAM clock-domain bridge.
- Executes single 16-bit word reads and writes on an external asynchronous SRAM, with programmable setup, strobe, hold and turnaround cycle counts.
- Returns read data with a one-cycle s_valid pulse. Holds s_busy for the whole access so the bridge can detect write completion.

Parameters:
- SETUP_CYCLES, 1: write address/data setup before WE# falls (min 1).
- WR_CYCLES, 3: WE# low width in cycles (min 1).
- HOLD_CYCLES, 1: data/address hold after WE# rises (min 1).
- RD_CYCLES, 3: OE# low cycles before data is sampled (min 1).
- TURN_CYCLES, 1: bus-idle cycles after any access (min 1).

Ports:
- s_clk  in  1  controller clock.
- s_rst  in  1  synchronous active-high reset.
- s_req  in  1  level, GDP memory session active; enables CE# while idle.
- s_wr_req  in  1  one-cycle write request pulse.
- s_rd_req  in  1  one-cycle read request pulse.
- s_addr  in  16  word address, sampled on accept.
- s_wdata  in  16  write data, sampled on accept.
- s_rdata  out  16  registered read data, held until the next read completes.
- s_valid  out  1  one-cycle pulse, s_rdata updated.
- s_busy  out  1  access in progress.
- s_err  out  1  sticky protocol error flag.
- s_err_clr  in  1  clears s_err.
- sram_addr  out  16  SRAM address.
- sram_dq_o  out  16  SRAM write data.
- sram_dq_i  in  16  SRAM read data.
- sram_dq_oe  out  1  data bus drive enable.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Interface decision: one clock (s_clk); reset s_rst is synchronous and active-high.
- Reset values (also applied on s_rst mid-access, aborting it; state goes to IDLE, no s_valid issued):
  - s_rdata=0, s_valid=0, s_err=0, sram_dq_oe=0, sram_dq_o=0, sram_addr=0.
  - ce_n, oe_n, we_n, ub_n, lb_n all =1.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_STROBE, TURN. One down-counter is loaded on each state entry.
- Accept: in IDLE, a request pulse in cycle T latches s_addr/s_wdata.
  - s_busy is combinational: (state!=IDLE) | ((s_wr_req|s_rd_req) & state==IDLE). It is therefore high in T itself, which the bridge checks on the cycle after issuing.
- Write (entered T+1):
  - WR_SETUP for SETUP_CYCLES: ce_n=0, ub/lb_n=0, dq_oe=1, we_n=1.
  - WR_PULSE for WR_CYCLES: we_n=0.
  - WR_HOLD for HOLD_CYCLES: we_n=1, dq_oe still 1.
  - TURN for TURN_CYCLES, then IDLE.
  - Defaults: s_busy high T..T+6, low from T+7.
- Read (entered T+1):
  - RD_STROBE for RD_CYCLES: ce_n=0, oe_n=0, ub/lb_n=0, dq_oe=0.
  - sram_dq_i is registered into s_rdata at the last RD_STROBE edge.
  - s_valid=1 for exactly the first TURN cycle (T+RD_CYCLES+1; T+4 with defaults).
  - oe_n=1 throughout TURN.
  - Defaults: IDLE at T+5.
- Idle strobes: sram_ce_n = ~s_req; oe_n/we_n=1; dq_oe=0.
- dq_oe and oe_n are never both active in the same cycle. A TURN of at least 1 cycle separates every access from the next.
- Simultaneous s_wr_req & s_rd_req in IDLE: write executes, read dropped, s_err set.
- Request pulse while state!=IDLE: ignored, s_err set. The in-flight access is unaffected.
- s_err_clr and a new error in the same cycle: set wins.
- The counter never wraps: each state exits on count==0 and reloads on entry.

Optional Feature:
- Macro SRAM_WR_READBACK_EN.
- Defined: after WR_HOLD, a write performs a TURN cycle, then an internal RD_STROBE at the same address.
  - The sampled data is compared with the latched wdata. On mismatch s_err is set.
  - No s_valid is issued and s_rdata is unchanged.
  - s_busy is extended over the verify read and its TURN.
- Undefined: writes end with TURN as above and no compare logic exists.

Test Plan:
- Reset, then s_req=1 idle -> all strobes high except ce_n=0, s_busy=0, s_rdata=0x0000.
- Write pulse at T with addr 0x1234, data 0xA5C3, defaults -> dq_oe=1 T+1..T+5, we_n=0 exactly T+2..T+4 with sram_addr=0x1234 and dq_o=0xA5C3, s_busy low at T+7.
- Read pulse at T with addr 0x1234, SRAM model returning 0xA5C3 -> oe_n=0 T+1..T+3, s_valid only at T+4, s_rdata=0xA5C3, s_busy low at T+5.
- Read pulse at T+2 during a write -> ignored, s_err=1, write timing unchanged. Then s_err_clr -> s_err=0.
- s_wr_req and s_rd_req both high in IDLE -> write only, s_err=1. Then s_rst at T+3 of a new write -> we_n=1, dq_oe=0, s_busy=0 the next cycle.
- Readback enabled, model corrupts bit 0 of 0x00FF -> s_err=1 after the verify read, no s_valid. With a correct model s_err stays 0.
